// File: rtl/morse_req_scheduler.sv
// morse_req_scheduler: round-robin arbiter over ten digit request lines that
// keys out the Morse code of the granted digit on LASER, one character per
// grant, with unit timing derived from the clock frequency.
module morse_req_scheduler #(
  parameter int CLK_SPEED = 16000000,
  parameter int UNIT_HZ   = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] REQ,
  output logic       LASER,
  output logic       BUSY,
  output logic [3:0] GRANT_IDX,
  output logic       DONE
);

  localparam int U  = CLK_SPEED / UNIT_HZ;
  localparam int CW = $clog2(3 * U);
  localparam logic [CW-1:0] DOT_LD  = CW'(U - 1);
  localparam logic [CW-1:0] DASH_LD = CW'(3 * U - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MARK     = 2'd1,
    SPACE    = 2'd2,
    CHAR_GAP = 2'd3
  } state_t;

  // Five-symbol pattern for a digit; bit 0 is sent first, 1 = dash.
  function automatic logic [4:0] digit_pattern(input logic [3:0] d);
    logic [4:0] p;
    case (d)
      4'd0:    p = 5'b11111;
      4'd1:    p = 5'b11110;
      4'd2:    p = 5'b11100;
      4'd3:    p = 5'b11000;
      4'd4:    p = 5'b10000;
      4'd5:    p = 5'b00000;
      4'd6:    p = 5'b00001;
      4'd7:    p = 5'b00011;
      4'd8:    p = 5'b00111;
      4'd9:    p = 5'b01111;
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

  // First pending index found walking upward from last+1, wrapping 9 -> 0.
  function automatic logic [3:0] rr_pick(input logic [9:0] pend, input logic [3:0] last);
    logic [3:0] idx;
    logic [3:0] pick;
    logic       found;
    idx   = last;
    pick  = 4'd0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (idx == 4'd9) begin
        idx = 4'd0;
      end else begin
        idx = idx + 4'd1;
      end
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  logic [9:0]    s1_r, s2_r, s3_r;
  logic [9:0]    rise_s;
  logic [9:0]    pending_r;
  logic [9:0]    clear_s;
  logic [3:0]    winner_s;
  logic [4:0]    pat_next_s;
  logic          grant_s;
  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [4:0]    pat_r;
  logic [2:0]    sym_r;
  logic [3:0]    last_grant_r;

  assign rise_s = s2_r & ~s3_r;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_r <= 10'd0;
      s2_r <= 10'd0;
      s3_r <= 10'd0;
    end else begin
      s1_r <= REQ;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Grant decision: round-robin winner and the pending bit it clears.
  always_comb begin
    winner_s   = rr_pick(pending_r, last_grant_r);
    pat_next_s = digit_pattern(winner_s);
    grant_s    = (state_r == IDLE) && (pending_r != 10'd0);
    clear_s    = 10'd0;
    if (grant_s) begin
      clear_s = 10'd1 << winner_s;
    end else begin
      clear_s = 10'd0;
    end
  end

  // Pending requests; a coincident rise wins over the grant's clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_r <= 10'd0;
    end else begin
      pending_r <= (pending_r & ~clear_s) | rise_s;
    end
  end

  // Character sequencer; the pattern is shifted at the end of each mark so
  // that pat_r[0] always holds the symbol the next mark will send.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      LASER        <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      GRANT_IDX    <= 4'd0;
      last_grant_r <= 4'd9;
      cnt_r        <= {CW{1'b0}};
      pat_r        <= 5'd0;
      sym_r        <= 3'd0;
    end else begin
      DONE <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            GRANT_IDX    <= winner_s;
            last_grant_r <= winner_s;
            pat_r        <= pat_next_s;
            sym_r        <= 3'd0;
            cnt_r        <= pat_next_s[0] ? DASH_LD : DOT_LD;
            LASER        <= 1'b1;
            BUSY         <= 1'b1;
            state_r      <= MARK;
          end else begin
            state_r <= IDLE;
          end
        end
        MARK: begin
          if (cnt_r == {CW{1'b0}}) begin
            LASER <= 1'b0;
            pat_r <= {1'b0, pat_r[4:1]};
            if (sym_r == 3'd4) begin
              cnt_r   <= DASH_LD;
              state_r <= CHAR_GAP;
            end else begin
              cnt_r   <= DOT_LD;
              state_r <= SPACE;
            end
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        SPACE: begin
          if (cnt_r == {CW{1'b0}}) begin
            LASER   <= 1'b1;
            sym_r   <= sym_r + 3'd1;
            cnt_r   <= pat_r[0] ? DASH_LD : DOT_LD;
            state_r <= MARK;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        CHAR_GAP: begin
          if (cnt_r == {CW{1'b0}}) begin
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          LASER   <= 1'b0;
          BUSY    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_req_scheduler.sv
// Directed bench for morse_req_scheduler with U = 16 clock cycles.
module tb_morse_req_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] REQ;
  logic       LASER;
  logic       BUSY;
  logic [3:0] GRANT_IDX;
  logic       DONE;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic       grant_bad;
  logic [3:0] exp_grant;

  morse_req_scheduler #(.CLK_SPEED(160), .UNIT_HZ(10)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .LASER(LASER), .BUSY(BUSY), .GRANT_IDX(GRANT_IDX), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference encoding written from the digit rules.
  function automatic bit exp_dash(input int d, input int s);
    if (d == 0) return 1'b1;
    else if (d <= 5) return (s >= d);
    else return (s < (d - 5));
  endfunction

  // Count consecutive negedge samples with LASER at lvl (bounded).
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (LASER === lvl && n < 200) begin
      if (GRANT_IDX !== exp_grant || BUSY !== 1'b1) grant_bad = 1'b1;
      n++;
      @(negedge CLK);
    end
  endtask

  // Raise the request bits and check the 3-edge request latency.
  task automatic start_req(input logic [9:0] mask, input int d);
    REQ = REQ | mask;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("latency_low", LASER, 0);
    end
    @(negedge CLK);
    check("latency_laser", LASER, 1);
    check("latency_busy", BUSY, 1);
    check("latency_grant", GRANT_IDX, d);
  endtask

  // Called on the first sample with LASER high; returns on the DONE sample.
  task automatic check_char(input int d);
    int n;
    exp_grant = 4'(d);
    grant_bad = 1'b0;
    check("char_start_laser", LASER, 1);
    check("char_start_grant", GRANT_IDX, d);
    for (int s = 0; s < 5; s++) begin
      run_len(1'b1, n);
      check($sformatf("mark_len d%0d s%0d", d, s), n, exp_dash(d, s) ? 48 : 16);
      if (s < 4) begin
        run_len(1'b0, n);
        check($sformatf("space_len d%0d s%0d", d, s), n, 16);
      end
    end
    n = 0;
    while (LASER === 1'b0 && DONE === 1'b0 && n < 200) begin
      n++;
      @(negedge CLK);
    end
    check($sformatf("char_gap d%0d", d), n, 48);
    check("done_pulse", DONE, 1);
    check("done_not_busy", BUSY, 0);
    check("done_laser_off", LASER, 0);
    check($sformatf("grant_held d%0d", d), grant_bad, 0);
  endtask

  initial begin
    logic bad;
    int   n;
    RST = 1'b1;
    REQ = 10'd0;

    // 1. Reset
    repeat (3) @(negedge CLK);
    check("rst_laser", LASER, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_grant", GRANT_IDX, 0);
    RST = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      if (LASER !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || GRANT_IDX !== 4'd0) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);

    // 2. Digit 5, request held four cycles
    start_req(10'b0000100000, 5);
    REQ = 10'd0;
    check_char(5);
    @(negedge CLK);
    check("d5_done_once", DONE, 0);
    check("d5_idle", BUSY, 0);
    repeat (5) @(negedge CLK);

    // 3. Digit 0
    start_req(10'b0000000001, 0);
    REQ = 10'd0;
    check_char(0);
    @(negedge CLK);
    check("d0_done_once", DONE, 0);
    repeat (5) @(negedge CLK);

    // 4. Simultaneous 2 and 7: 2 first, 49-cycle off gap
    start_req(10'b0010000100, 2);
    REQ = 10'd0;
    check_char(2);
    @(negedge CLK);
    check("gap49_laser", LASER, 1);
    check("gap49_grant", GRANT_IDX, 7);

    // 5. 3 and 8 arrive while 7 is sent; 8 wins, held levels do not repeat
    REQ = 10'b0100001000;
    check_char(7);
    @(negedge CLK);
    check("rr_grant8", GRANT_IDX, 8);
    check_char(8);
    @(negedge CLK);
    check("rr_grant3", GRANT_IDX, 3);
    check_char(3);
    bad = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || LASER !== 1'b0) bad = 1'b1;
    end
    check("held_no_repeat", bad, 0);
    REQ = 10'd0;
    repeat (5) @(negedge CLK);

    // 6. Reset during the second dash of digit 0 with REQ[0] still high
    start_req(10'b0000000001, 0);
    exp_grant = 4'd0;
    grant_bad = 1'b0;
    run_len(1'b1, n);
    check("mid_first_dash", n, 48);
    run_len(1'b0, n);
    check("mid_first_space", n, 16);
    repeat (5) @(negedge CLK);
    check("mid_in_dash", LASER, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_laser", LASER, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_grant", GRANT_IDX, 0);
    check("mid_rst_done", DONE, 0);
    @(negedge CLK);
    RST = 1'b0;
    start_req(10'b0000000001, 0);
    check_char(0);
    bad = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || LASER !== 1'b0) bad = 1'b1;
    end
    check("restart_once", bad, 0);
    REQ = 10'd0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/morse_req_scheduler.md
# morse_req_scheduler

Arbitrates Morse transmit requests from the ten digit inputs, PIN_14..PIN_24 (excluding PIN_20), and sequences the laser/LED key output. Each requester index i (0..9) transmits the Morse code for decimal digit i. Requests are served round-robin, one character at a time, with standard Morse unit timing derived from `CLK_SPEED`. The block sits between the top-level pin inputs and the laser/LED drive in the LaserMorse top.

## Interface
- `CLK_SPEED`, default 16000000: CLK frequency in Hz.
- `UNIT_HZ`, default 10: Morse units per second. U = CLK_SPEED / UNIT_HZ cycles, integer division. U must be ≥ 2.
- `CLK`  in  1: system clock; all logic on the rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `REQ`  in  10: asynchronous request levels; bit i requests digit i.
- `LASER`  out  1: Morse key, registered; 1 = emitting.
- `BUSY`  out  1: high in every state except IDLE.
- `GRANT_IDX`  out  4: index being sent; valid and held while BUSY.
- `DONE`  out  1: one-cycle pulse when a character finishes.

## Operation
- **Input conditioning.** Each REQ bit passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - Rising edge is rise[i] = s2 & ~s3.
  - A rise sets pending[i]. A level held high produces exactly one request.
  - REQ must be high for ≥ 2 CLK cycles to be guaranteed seen.
- **Encoding.** Each digit is 5 symbols, sent first-to-last.
  - d = 1..5: d dots, then 5−d dashes.
  - d = 6..9: d−5 dashes, then dots.
  - d = 0: five dashes.
  - Encoding is combinational from the granted index into a 5-bit shift register (1 = dash). A symbol counter runs 0..4.
- **Durations.** Dot = 1U on. Dash = 3U on. Intra-character gap = 1U off. Inter-character gap = 3U off.
- **Unit counter.** A duration counter reloads at each state entry. Its width fits 3U−1.
- **States.**
  - IDLE: if pending ≠ 0, grant the round-robin winner, clear its pending bit, load the pattern, set LASER←1 → MARK. Otherwise hold.
  - MARK: count 1U or 3U according to the current symbol. At expiry, LASER←0. Go to SPACE if symbols remain, else to CHAR_GAP.
  - SPACE: 1U off, then LASER←1, advance the symbol → MARK.
  - CHAR_GAP: 3U off, then pulse DONE → IDLE.
- **Round-robin.** The search starts at (last_grant+1) mod 10 and wraps 9→0. last_grant updates on each grant. After reset last_grant = 9, so index 0 has first priority.
- **Simultaneous set and clear.** If a rise on index i coincides with the grant clearing pending[i], the set wins and i is re-queued.
- **New requests while BUSY.** These only set pending. GRANT_IDX and the pattern are not disturbed.
- **Reset.** RST at any cycle, including mid-mark, forces the following on the next edge:
  - state IDLE; LASER, BUSY and DONE = 0; GRANT_IDX = 0.
  - pending, s1, s2 and s3 = 0; last_grant = 9.
  - A REQ held high through reset is seen as a new rise after release.

## Timing
- All outputs are registered. Reset values: LASER 0, BUSY 0, GRANT_IDX 0, DONE 0.
- **Request latency.** Edge 0 first samples REQ high. pending is set at edge 2. When IDLE, LASER and BUSY rise at edge 3, with GRANT_IDX valid.
- **Mark and gap lengths.** Each mark or gap lasts exactly the specified multiple of U cycles. There are no extra cycles between segments.
- **Character length.** Total time from LASER rise to DONE is the sum of the symbols + 4U + 3U.
- **Character end.** DONE is high for the single cycle in which the state is IDLE and BUSY is 0.
  - If pending ≠ 0 at that point, the next grant occurs on the following edge.
  - Back-to-back characters therefore have a 3U + 1 cycle off gap.

## Test plan
All scenarios use CLK_SPEED=160 and UNIT_HZ=10, so U = 16.
1. **Reset.** Assert RST for 3 cycles with REQ=0 → LASER, BUSY, DONE, GRANT_IDX all 0. Outputs stay 0 for 100 cycles after release.
2. **Digit 5.** Rise REQ[5], held for 4 cycles.
   - LASER rises 3 edges after first sample. Pattern is 16 on / 16 off ×4, then 16 on, then 48 off.
   - DONE pulses once. GRANT_IDX = 5 throughout.
3. **Digit 0.** Rise REQ[0] → five 48-cycle marks separated by 16-cycle gaps. DONE pulses 48 cycles after the last mark.
4. **Simultaneous requests.** Rise REQ[2] and REQ[7] on the same cycle.
   - Digit 2 (..---) is sent first, then digit 7 (--...).
   - LASER is off for 49 cycles between the two characters.
5. **Round-robin fairness.** While sending 7, rise REQ[3] and REQ[8] → 8 is served before 3. Holding REQ[8] high afterwards causes no repeat.
6. **Reset mid-operation.** Assert RST during the second dash of digit 0 while REQ[0] is still high.
   - LASER = 0 at the next edge. BUSY = 0. pending is cleared.
   - After release, digit 0 restarts once (re-seen rise) and completes normally.
